// File: rtl/fifo_watermark.sv
// Single-channel synchronous FIFO with hysteresis watermark flags.
// Feeds per-channel pause/continue/empty/full/error status to flow control.
module fifo_watermark #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int HIGH_TH    = 6,
    parameter int LOW_TH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_pause,
    output logic                  fifo_continue,
    output logic                  fifo_error
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_HIGH  = CW'(HIGH_TH);
    localparam logic [CW-1:0] C_LOW   = CW'(LOW_TH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PINC = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_pause;
    logic                  r_continue;
    logic                  r_error;

    logic          w_is_full;
    logic          w_is_empty;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic          w_err_evt;
    logic [CW-1:0] w_count_nxt;
    logic          w_pause_nxt;

    assign w_is_full  = (r_count == C_DEPTH);
    assign w_is_empty = (r_count == '0);

    // A push on a full FIFO only gets in when a pop frees a slot
    // at the same edge; no bypass path exists when empty.
    assign w_pop_ok  = pop & ~w_is_empty;
    assign w_push_ok = push & (~w_is_full | w_pop_ok);

    // Rejected push while full, or any pop attempt while empty.
    assign w_err_evt = (push & w_is_full & ~w_pop_ok)
                     | (pop & w_is_empty);

    // Next occupancy and the hysteresis decision taken on it, so
    // pause asserts on the very edge the count reaches HIGH_TH.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + C_ONE;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - C_ONE;
        end
        w_pause_nxt = r_pause;
        if (w_count_nxt >= C_HIGH) begin
            w_pause_nxt = 1'b1;
        end else if (w_count_nxt <= C_LOW) begin
            w_pause_nxt = 1'b0;
        end
    end

    // Storage array: never cleared, written only by accepted pushes.
    always_ff @(posedge clk) begin
        if (!init && w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, read register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_pause    <= 1'b0;
            r_continue <= 1'b0;
            r_error    <= 1'b0;
        end else if (init) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_pause    <= 1'b0;
            r_continue <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PINC;
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + C_PINC;
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_valid    <= w_pop_ok;
            r_count    <= w_count_nxt;
            r_pause    <= w_pause_nxt;
            r_continue <= r_pause & ~w_pause_nxt;
            if (w_err_evt) begin
                r_error <= 1'b1;
            end
        end
    end

    assign data_out      = r_data_out;
    assign valid_out     = r_valid;
    assign count         = r_count;
    assign fifo_full     = w_is_full;
    assign fifo_empty    = w_is_empty;
    assign fifo_pause    = r_pause;
    assign fifo_continue = r_continue;
    assign fifo_error    = r_error;

endmodule
